// File: rtl/cdb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared constants and helpers for the common-data-bus arbiter.
//
// `ROB_WIDTH_BIT and the requester indices normally come from the shared
// const.v. The guarded default below only applies when const.v has not been
// included earlier in the compile.
//
// Contents:
//   cdb_src_e  - requester index of each write-back unit (ALU/RS, LSB, BRU)
//   CDB_DATA_W - width of a broadcast result value
//   next_index - modulo increment used to advance the round-robin pointer
// ----------------------------------------------------------------------------
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

package cdb_arbiter_pkg;

    typedef enum logic [1:0] {
        CDB_SRC_ALU = 2'd0,
        CDB_SRC_LSB = 2'd1,
        CDB_SRC_BRU = 2'd2
    } cdb_src_e;

    localparam int CDB_DATA_W = 32;

    // Advances an index by one and wraps it to zero at n.
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_req_queue.sv
// ----------------------------------------------------------------------------
// cdb_req_queue
// Small FIFO that holds the results one requester has produced but that
// have not been broadcast yet. The arbiter gates push and pop, so this block
// only does the bookkeeping. A flush takes priority over everything else.
//
// Ports:
//   clk_in     - clock, rising edge
//   rst_n_in   - asynchronous active-low reset
//   push       - write push_data at the tail
//   push_data  - {rob_id, value} entry
//   pop        - drop the current head
//   flush      - empty the queue and ignore push/pop this edge
//   count      - number of valid entries (0..DEPTH)
//   head       - oldest entry; only meaningful when count != 0
// ----------------------------------------------------------------------------
module cdb_req_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // A push and a pop at the same edge leave the occupancy unchanged.
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage has no reset; the count alone decides which entries are live.
    always_ff @(posedge clk_in) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
// Collects write-back results from NUM_REQ execution units. Each unit has
// its own holding queue. Every active cycle the arbiter picks at most one
// queue head and broadcasts it on the registered common data bus.
//
// Optional feature: when CDB_OLDEST_FIRST_EN is defined, the grant goes to
// the head closest to rob_id_head (oldest instruction), and ties go to the
// lowest index. Otherwise arbitration is round-robin and rob_id_head is
// ignored.
//
// Ports:
//   clk_in, rst_n_in        - clock (rising edge), asynchronous active-low reset
//   rdy_in                  - global ready; low freezes the whole block
//   clear                   - mispredict flush: empties queues, drops pushes
//   rob_id_head             - oldest ROB entry (oldest-first mode only)
//   req_valid / req_ready   - per-requester handshake
//   req_rob_id / req_value  - flattened entries, requester i at slice i
//   cdb_valid/rob_id/value  - registered broadcast, one-cycle pulse per grant
//   cdb_src                 - index of the requester behind the broadcast
// ----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int QUEUE_DEPTH  = 2,
    parameter int ROB_SIZE_BIT = `ROB_WIDTH_BIT
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              rdy_in,
    input  logic                              clear,
    input  logic [ROB_SIZE_BIT-1:0]           rob_id_head,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*ROB_SIZE_BIT-1:0]   req_rob_id,
    input  logic [NUM_REQ*CDB_DATA_W-1:0]     req_value,
    output logic                              cdb_valid,
    output logic [ROB_SIZE_BIT-1:0]           cdb_rob_id,
    output logic [CDB_DATA_W-1:0]             cdb_value,
    output logic [$clog2(NUM_REQ)-1:0]        cdb_src
);

    localparam int SRC_W   = $clog2(NUM_REQ);
    localparam int ENTRY_W = ROB_SIZE_BIT + CDB_DATA_W;
    localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;

    logic [CNT_W-1:0]   count [NUM_REQ];
    logic [ENTRY_W-1:0] head  [NUM_REQ];
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] nonempty;
    logic               active;
    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [ENTRY_W-1:0] grant_entry;

    assign active = rdy_in && !clear;

    // Ready comes only from the registered count. A full queue refuses an
    // entry even when its head is popped at the same edge.
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : gen_queue
            assign req_ready[g] = rst_n_in && active && (count[g] < CNT_W'(QUEUE_DEPTH));
            assign push[g]      = req_valid[g] && req_ready[g];
            assign nonempty[g]  = (count[g] != '0);
            assign pop[g]       = active && grant_valid && (grant_idx == SRC_W'(g));

            cdb_req_queue #(
                .DEPTH (QUEUE_DEPTH),
                .WIDTH (ENTRY_W)
            ) u_queue (
                .clk_in    (clk_in),
                .rst_n_in  (rst_n_in),
                .push      (push[g]),
                .push_data ({req_rob_id[g*ROB_SIZE_BIT +: ROB_SIZE_BIT],
                             req_value[g*CDB_DATA_W +: CDB_DATA_W]}),
                .pop       (pop[g]),
                .flush     (clear),
                .count     (count[g]),
                .head      (head[g])
            );
        end
    endgenerate

`ifdef CDB_OLDEST_FIRST_EN
    logic [ROB_SIZE_BIT-1:0] age;
    logic [ROB_SIZE_BIT-1:0] best_age;

    // Age is the head's distance from the ROB head modulo the ROB size, so
    // the comparison stays correct when ROB ids wrap around. The strict '<'
    // keeps the lowest index on a tie.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_entry = '0;
        age         = '0;
        best_age    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            age = head[i][ENTRY_W-1 -: ROB_SIZE_BIT] - rob_id_head;
            if (nonempty[i] && (!grant_valid || age < best_age)) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(i);
                grant_entry = head[i];
                best_age    = age;
            end
        end
    end
`else
    logic [SRC_W-1:0] rr_ptr;
    int               cand;
    logic             unused_rob_id_head;

    assign unused_rob_id_head = ^rob_id_head;

    // Round-robin: the search starts at rr_ptr and takes the first
    // non-empty queue, wrapping past the last requester.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_entry = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_valid && nonempty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(cand);
                grant_entry = head[cand];
            end
        end
    end
`endif

    // Broadcast register. A flush wins over rdy_in. While rdy_in is low,
    // every register holds its value, so an in-flight grant stays on the bus.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= '0;
`ifndef CDB_OLDEST_FIRST_EN
            rr_ptr     <= '0;
`endif
        end else if (clear) begin
            cdb_valid  <= 1'b0;
`ifndef CDB_OLDEST_FIRST_EN
            rr_ptr     <= '0;
`endif
        end else if (rdy_in) begin
            cdb_valid <= grant_valid;
            if (grant_valid) begin
                cdb_rob_id <= grant_entry[ENTRY_W-1 -: ROB_SIZE_BIT];
                cdb_value  <= grant_entry[CDB_DATA_W-1:0];
                cdb_src    <= grant_idx;
`ifndef CDB_OLDEST_FIRST_EN
                rr_ptr     <= SRC_W'(next_index(int'(grant_idx), NUM_REQ));
`endif
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter. A queue-based reference model tracks
// what the bus must show. Hand-written literal expectations pin the
// scenarios: single request, contention, backpressure, flush, stall,
// mid-operation reset and, with CDB_OLDEST_FIRST_EN, oldest-first order.
// ----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NREQ  = 3;
    localparam int QDEP  = 2;
    localparam int ROB_W = 4;

    logic                  clk_in = 1'b0;
    logic                  rst_n_in = 1'b0;
    logic                  rdy_in = 1'b1;
    logic                  clear = 1'b0;
    logic [ROB_W-1:0]      rob_id_head = '0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ROB_W-1:0] req_rob_id = '0;
    logic [NREQ*32-1:0]    req_value = '0;
    logic                  cdb_valid;
    logic [ROB_W-1:0]      cdb_rob_id;
    logic [31:0]           cdb_value;
    logic [1:0]            cdb_src;

    int n_checks = 0;
    int n_errors = 0;

    cdb_arbiter #(
        .NUM_REQ      (NREQ),
        .QUEUE_DEPTH  (QDEP),
        .ROB_SIZE_BIT (ROB_W)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .clear       (clear),
        .rob_id_head (rob_id_head),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rob_id  (req_rob_id),
        .req_value   (req_value),
        .cdb_valid   (cdb_valid),
        .cdb_rob_id  (cdb_rob_id),
        .cdb_value   (cdb_value),
        .cdb_src     (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: one queue per requester plus the expected bus state.
    logic [ROB_W-1:0] mq_id  [NREQ][$];
    logic [31:0]      mq_val [NREQ][$];
    logic             m_valid = 1'b0;
    logic [ROB_W-1:0] m_id = '0;
    logic [31:0]      m_val = '0;
    logic [1:0]       m_src = '0;
    int               m_rr = 0;
    int               m_grant;
    int               m_best;
    int               m_age;
    logic [NREQ-1:0]  m_acc;
    logic [NREQ-1:0]  exp_ready;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREQ; i++) begin
                mq_id[i].delete();
                mq_val[i].delete();
            end
            m_valid = 1'b0;
            m_id    = '0;
            m_val   = '0;
            m_src   = '0;
            m_rr    = 0;
        end else if (clear) begin
            for (int i = 0; i < NREQ; i++) begin
                mq_id[i].delete();
                mq_val[i].delete();
            end
            m_valid = 1'b0;
            m_rr    = 0;
        end else if (rdy_in) begin
            for (int i = 0; i < NREQ; i++) begin
                m_acc[i] = req_valid[i] && (mq_id[i].size() < QDEP);
            end
            m_grant = -1;
`ifdef CDB_OLDEST_FIRST_EN
            m_best = 1 << ROB_W;
            for (int i = 0; i < NREQ; i++) begin
                if (mq_id[i].size() > 0) begin
                    m_age = ((int'(mq_id[i][0]) - int'(rob_id_head)) % (1 << ROB_W) + (1 << ROB_W)) % (1 << ROB_W);
                    if (m_age < m_best) begin
                        m_best  = m_age;
                        m_grant = i;
                    end
                end
            end
`else
            for (int k = 0; k < NREQ; k++) begin
                if (m_grant < 0 && mq_id[(m_rr + k) % NREQ].size() > 0) begin
                    m_grant = (m_rr + k) % NREQ;
                end
            end
`endif
            if (m_grant >= 0) begin
                m_valid = 1'b1;
                m_id    = mq_id[m_grant].pop_front();
                m_val   = mq_val[m_grant].pop_front();
                m_src   = 2'(m_grant);
                m_rr    = (m_grant + 1) % NREQ;
            end else begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (m_acc[i]) begin
                    mq_id[i].push_back(req_rob_id[i*ROB_W +: ROB_W]);
                    mq_val[i].push_back(req_value[i*32 +: 32]);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        for (int i = 0; i < NREQ; i++) begin
            exp_ready[i] = rst_n_in && rdy_in && !clear && (mq_id[i].size() < QDEP);
        end
        check_output("model_req_ready", 32'(req_ready), 32'(exp_ready));
        check_output("model_cdb_valid", 32'(cdb_valid), 32'(m_valid));
        check_output("model_cdb_rob_id", 32'(cdb_rob_id), 32'(m_id));
        check_output("model_cdb_value", cdb_value, m_val);
        check_output("model_cdb_src", 32'(cdb_src), 32'(m_src));
    end

    task automatic apply_stimulus(input logic [2:0] v,
                                  input logic [3:0] id0, input logic [3:0] id1, input logic [3:0] id2,
                                  input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        req_valid  = v;
        req_rob_id = {id2, id1, id0};
        req_value  = {d2, d1, d0};
    endtask

    task automatic idle();
        apply_stimulus(3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    initial begin
        idle();
        #1;
        check_output("reset_cdb_valid", 32'(cdb_valid), 32'd0);
        check_output("reset_req_ready", 32'(req_ready), 32'd0);
        check_output("reset_cdb_src", 32'(cdb_src), 32'd0);
        repeat (2) step();
        rst_n_in = 1'b1;

        // Single request: visible only after the second edge.
        apply_stimulus(3'b001, 4'd5, 4'd0, 4'd0, 32'h1234, 32'd0, 32'd0);
        step();
        check_output("single_not_early", 32'(cdb_valid), 32'd0);
        idle();
        step();
        check_output("single_valid", 32'(cdb_valid), 32'd1);
        check_output("single_rob_id", 32'(cdb_rob_id), 32'd5);
        check_output("single_value", cdb_value, 32'h1234);
        check_output("single_src", 32'(cdb_src), 32'd0);
        step();
        check_output("single_pulse", 32'(cdb_valid), 32'd0);

        clear = 1'b1;
        step();
        clear = 1'b0;

`ifndef CDB_OLDEST_FIRST_EN
        // Contention from rr_ptr=0: grants go 0, 1, 2 in turn.
        apply_stimulus(3'b111, 4'd1, 4'd2, 4'd3, 32'hA0, 32'hA1, 32'hA2);
        step();
        idle();
        step();
        check_output("contend_src0", 32'(cdb_src), 32'd0);
        check_output("contend_rob1", 32'(cdb_rob_id), 32'd1);
        step();
        check_output("contend_src1", 32'(cdb_src), 32'd1);
        check_output("contend_rob2", 32'(cdb_rob_id), 32'd2);
        step();
        check_output("contend_src2", 32'(cdb_src), 32'd2);
        check_output("contend_rob3", 32'(cdb_rob_id), 32'd3);
        step();
        check_output("contend_done", 32'(cdb_valid), 32'd0);

        // Backpressure: the LSB queue fills to two, and its third entry waits.
        apply_stimulus(3'b111, 4'd4, 4'd5, 4'd6, 32'hB0, 32'hB1, 32'hB2);
        step();
        apply_stimulus(3'b011, 4'd7, 4'd8, 4'd0, 32'hB3, 32'hB4, 32'd0);
        step();
        check_output("rr_back_to_0", 32'(cdb_src), 32'd0);
        check_output("rr_rob4", 32'(cdb_rob_id), 32'd4);
        apply_stimulus(3'b010, 4'd0, 4'd9, 4'd0, 32'd0, 32'hB5, 32'd0);
        #1;
        check_output("lsb_full_ready", 32'(req_ready), 32'b101);
        step();
        check_output("lsb_grant_src", 32'(cdb_src), 32'd1);
        check_output("lsb_grant_rob", 32'(cdb_rob_id), 32'd5);
        check_output("lsb_ready_again", 32'(req_ready), 32'b111);
        step();
        check_output("bru_grant_rob", 32'(cdb_rob_id), 32'd6);
        idle();
        step();
        check_output("alu_grant_rob", 32'(cdb_rob_id), 32'd7);
        step();
        check_output("lsb_second_rob", 32'(cdb_rob_id), 32'd8);
        step();
        check_output("lsb_third_src", 32'(cdb_src), 32'd1);
        check_output("lsb_third_rob", 32'(cdb_rob_id), 32'd9);
        step();
        check_output("bp_drained", 32'(cdb_valid), 32'd0);
`else
        // Oldest-first wrap-around: rob 15 is age 1 from head 14; rob 1 is age 3.
        rob_id_head = 4'd14;
        apply_stimulus(3'b101, 4'd1, 4'd0, 4'd15, 32'hC0, 32'd0, 32'hC2);
        step();
        idle();
        step();
        check_output("oldest_src2", 32'(cdb_src), 32'd2);
        check_output("oldest_rob15", 32'(cdb_rob_id), 32'd15);
        step();
        check_output("oldest_then_src0", 32'(cdb_src), 32'd0);
        check_output("oldest_then_rob1", 32'(cdb_rob_id), 32'd1);
        step();
        rob_id_head = 4'd0;
`endif

        // Flush with entries queued everywhere and pushes still requested.
        apply_stimulus(3'b111, 4'd10, 4'd11, 4'd12, 32'hD0, 32'hD1, 32'hD2);
        step();
        apply_stimulus(3'b111, 4'd13, 4'd14, 4'd15, 32'hD3, 32'hD4, 32'hD5);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        idle();
        #1;
        check_output("flush_valid", 32'(cdb_valid), 32'd0);
        check_output("flush_ready", 32'(req_ready), 32'b111);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("flush_no_old", 32'(cdb_valid), 32'd0);
        end

        // Stall: with rdy_in low, the in-flight grant holds on the bus.
        apply_stimulus(3'b011, 4'd3, 4'd4, 4'd0, 32'hE0, 32'hE1, 32'd0);
        step();
        idle();
        step();
        check_output("stall_pre_rob", 32'(cdb_rob_id), 32'd3);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("stall_valid", 32'(cdb_valid), 32'd1);
            check_output("stall_rob", 32'(cdb_rob_id), 32'd3);
            check_output("stall_value", cdb_value, 32'hE0);
            check_output("stall_ready", 32'(req_ready), 32'd0);
        end
        rdy_in = 1'b1;
        step();
        check_output("resume_src", 32'(cdb_src), 32'd1);
        check_output("resume_rob", 32'(cdb_rob_id), 32'd4);
        step();
        check_output("resume_done", 32'(cdb_valid), 32'd0);

        // Reset mid-operation discards everything queued.
        apply_stimulus(3'b111, 4'd1, 4'd2, 4'd3, 32'hF0, 32'hF1, 32'hF2);
        step();
        step();
        #1;
        rst_n_in = 1'b0;
        #1;
        check_output("midreset_valid", 32'(cdb_valid), 32'd0);
        check_output("midreset_ready", 32'(req_ready), 32'd0);
        check_output("midreset_value", cdb_value, 32'd0);
        idle();
        step();
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("midreset_empty", 32'(cdb_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
